// File: rtl/logic_unit_pkg.sv
// Shared definitions for the serial logic unit: operation encodings and FSM states.
package logic_unit_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/logic_slice.sv
// Combinational W-bit bitwise operation mux (AND/OR/XOR/NOR).
module logic_slice
    import logic_unit_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_serial.sv
// Multi-cycle bitwise logic unit processing SLICE bits per cycle behind valid/ready handshakes.
// Optional parity output enabled by defining LOGIC_UNIT_PARITY_EN.
module logic_unit_serial
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] first,
    input  logic [WIDTH-1:0] second,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic [SLICE-1:0] y_slice;
    logic [WIDTH-1:0] result_next;
    logic             last;

    assign last    = (cnt == LAST_CNT);
    assign a_slice = a_q[cnt*SLICE +: SLICE];
    assign b_slice = b_q[cnt*SLICE +: SLICE];

    logic_slice #(.W(SLICE)) u_slice (
        .a  (a_slice),
        .b  (b_slice),
        .op (op_q),
        .y  (y_slice)
    );

    // Merge the freshly computed slice into the held result; zero/parity look at this full word.
    always_comb begin
        result_next = result;
        result_next[cnt*SLICE +: SLICE] = y_slice;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = S_BUSY;
            end
            S_BUSY: begin
                if (last) state_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand latch, slice counter and result/flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_AND;
            cnt    <= '0;
            result <= '0;
            zero   <= 1'b0;
`ifdef LOGIC_UNIT_PARITY_EN
            parity <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q  <= first;
                        b_q  <= second;
                        op_q <= op;
                        cnt  <= '0;
                    end
                end
                S_BUSY: begin
                    result <= result_next;
                    if (last) begin
                        cnt  <= '0;
                        zero <= (result_next == '0);
`ifdef LOGIC_UNIT_PARITY_EN
                        parity <= ^result_next;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_unit_serial.sv
// Self-checking bench for logic_unit_serial: default 32/8 instance plus a 16/16 single-slice instance.
module tb_logic_unit_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, zero;
    logic [1:0]  op;
    logic [31:0] first, second, result;

    logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_zero;
    logic [1:0]  p_op;
    logic [15:0] p_first, p_second, p_result;
`ifdef LOGIC_UNIT_PARITY_EN
    logic        parity, p_parity;
`endif

    int total = 0;
    int bad   = 0;

    logic_unit_serial #(.WIDTH(32), .SLICE(8)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .first     (first),
        .second    (second),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
`ifdef LOGIC_UNIT_PARITY_EN
        ,
        .parity    (parity)
`endif
    );

    logic_unit_serial #(.WIDTH(16), .SLICE(16)) u_one (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (p_in_valid),
        .in_ready  (p_in_ready),
        .op        (p_op),
        .first     (p_first),
        .second    (p_second),
        .out_valid (p_out_valid),
        .out_ready (p_out_ready),
        .result    (p_result),
        .zero      (p_zero)
`ifdef LOGIC_UNIT_PARITY_EN
        ,
        .parity    (p_parity)
`endif
    );

    function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] o);
        case (o)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic start_req(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
        first    = a;
        second   = b;
        op       = o;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the acceptance edge until out_valid, optionally scrambling operands.
    task automatic wait_result(input bit scramble, output int cyc);
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (scramble) begin
                first  = $urandom;
                second = $urandom;
                op     = 2'($urandom);
            end
            if (out_valid) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (result !== 32'h0)   begin bad++; $display("[TB] FAIL reset_result got=%h exp=0", result); end
        total++; if (zero !== 1'b0)      begin bad++; $display("[TB] FAIL reset_zero got=%b exp=0", zero); end
        total++; if (p_result !== 16'h0) begin bad++; $display("[TB] FAIL reset_p_result got=%h exp=0", p_result); end
`ifdef LOGIC_UNIT_PARITY_EN
        total++; if (parity !== 1'b0)    begin bad++; $display("[TB] FAIL reset_parity got=%b exp=0", parity); end
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fixed_ops();
        logic [31:0] va[5]  = '{32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'h12345678};
        logic [31:0] vb[5]  = '{32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h12345678};
        logic [1:0]  vo[5]  = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10};
        logic [31:0] ve[5]  = '{32'hF0F00F0F, 32'h0F0F0000, 32'hFFFF0F0F, 32'h0000F0F0, 32'h00000000};
        int cyc;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start_req(va[i], vb[i], vo[i]);
            wait_result(1'b0, cyc);
            total++; if (cyc != 4)           begin bad++; $display("[TB] FAIL fixed_latency[%0d] got=%0d exp=4", i, cyc); end
            total++; if (result !== ve[i])   begin bad++; $display("[TB] FAIL fixed_result[%0d] got=%h exp=%h", i, result, ve[i]); end
            total++; if (zero !== (ve[i] == 32'h0)) begin bad++; $display("[TB] FAIL fixed_zero[%0d] got=%b exp=%b", i, zero, ve[i] == 32'h0); end
`ifdef LOGIC_UNIT_PARITY_EN
            total++; if (parity !== ^ve[i])  begin bad++; $display("[TB] FAIL fixed_parity[%0d] got=%b exp=%b", i, parity, ^ve[i]); end
`endif
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        int cyc;
        exp = ref_op(32'hA5A5_F00F, 32'h3C3C_0FF0, 2'b00);
        out_ready = 1'b0;
        start_req(32'hA5A5_F00F, 32'h3C3C_0FF0, 2'b00);
        wait_result(1'b0, cyc);
        total++; if (cyc != 4) begin bad++; $display("[TB] FAIL bp_latency got=%0d exp=4", cyc); end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            first    = $urandom;
            second   = $urandom;
            op       = 2'($urandom);
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp) begin
                bad++; $display("[TB] FAIL bp_hold[%0d] got v=%b r=%b res=%h exp v=1 r=0 res=%h", i, out_valid, in_ready, result, exp);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL bp_release got r=%b v=%b exp r=1 v=0", in_ready, out_valid);
        end
        total++; if (result !== exp) begin bad++; $display("[TB] FAIL bp_result_after got=%h exp=%h", result, exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_random_scramble();
        logic [31:0] a, b, exp;
        logic [1:0]  o;
        int cyc;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i == 3) ? a : $urandom;
            o = (i == 3) ? 2'b10 : 2'($urandom);
            exp = ref_op(a, b, o);
            start_req(a, b, o);
            wait_result(1'b1, cyc);
            total++; if (cyc != 4)         begin bad++; $display("[TB] FAIL rand_latency[%0d] got=%0d exp=4", i, cyc); end
            total++; if (result !== exp)   begin bad++; $display("[TB] FAIL rand_result[%0d] got=%h exp=%h", i, result, exp); end
            total++; if (zero !== (exp == 32'h0)) begin bad++; $display("[TB] FAIL rand_zero[%0d] got=%b exp=%b", i, zero, exp == 32'h0); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] exp;
        int cyc;
        out_ready = 1'b1;
        start_req(32'hDEADBEEF, 32'h0000FFFF, 2'b01);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b0) begin
            bad++; $display("[TB] FAIL midop_reset got r=%b v=%b res=%h z=%b exp r=1 v=0 res=0 z=0", in_ready, out_valid, result, zero);
        end
        #3;
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL midop_idle got r=%b v=%b exp r=1 v=0", in_ready, out_valid);
        end
        exp = ref_op(32'h0F1E2D3C, 32'hFFFF0000, 2'b11);
        start_req(32'h0F1E2D3C, 32'hFFFF0000, 2'b11);
        wait_result(1'b0, cyc);
        total++; if (cyc != 4 || result !== exp) begin
            bad++; $display("[TB] FAIL midop_after got cyc=%0d res=%h exp cyc=4 res=%h", cyc, result, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        int cyc;
        out_ready = 1'b1;
        start_req(32'h11112222, 32'h33334444, 2'b10);
        wait_result(1'b0, cyc);
        exp = ref_op(32'h11112222, 32'h33334444, 2'b10);
        total++; if (result !== exp) begin bad++; $display("[TB] FAIL b2b_first got=%h exp=%h", result, exp); end
        first    = 32'hCAFEF00D;
        second   = 32'h0000FFFF;
        op       = 2'b00;
        in_valid = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL b2b_no_bypass got r=%b v=%b exp r=1 v=0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL b2b_accept got r=%b exp r=0", in_ready); end
        wait_result(1'b0, cyc);
        exp = 32'hCAFEF00D & 32'h0000FFFF;
        total++; if (cyc != 4 || result !== exp) begin
            bad++; $display("[TB] FAIL b2b_second got cyc=%0d res=%h exp cyc=4 res=%h", cyc, result, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_slice();
        logic [15:0] a[2] = '{16'h0001, 16'hBEEF};
        logic [15:0] b[2] = '{16'h0000, 16'h1234};
        logic [1:0]  o[2] = '{2'b01, 2'b10};
        logic [15:0] exp;
        int cyc;
        p_out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp = 16'(ref_op({16'h0, a[i]}, {16'h0, b[i]}, o[i]));
            p_first    = a[i];
            p_second   = b[i];
            p_op       = o[i];
            p_in_valid = 1'b1;
            @(posedge clk); #1;
            p_in_valid = 1'b0;
            cyc = 0;
            while (cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
                if (p_out_valid) break;
            end
            total++; if (cyc != 1)          begin bad++; $display("[TB] FAIL one_latency[%0d] got=%0d exp=1", i, cyc); end
            total++; if (p_result !== exp)  begin bad++; $display("[TB] FAIL one_result[%0d] got=%h exp=%h", i, p_result, exp); end
            total++; if (p_zero !== 1'b0)   begin bad++; $display("[TB] FAIL one_zero[%0d] got=%b exp=0", i, p_zero); end
`ifdef LOGIC_UNIT_PARITY_EN
            total++; if (p_parity !== ^exp) begin bad++; $display("[TB] FAIL one_parity[%0d] got=%b exp=%b", i, p_parity, ^exp); end
`endif
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        op          = 2'b00;
        first       = '0;
        second      = '0;
        p_in_valid  = 1'b0;
        p_out_ready = 1'b1;
        p_op        = 2'b00;
        p_first     = '0;
        p_second    = '0;
        test_reset();
        test_fixed_ops();
        test_backpressure();
        test_random_scramble();
        test_reset_midop();
        test_back_to_back();
        test_single_slice();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
